store_merge_unit: RTL and testbench

Store-side counterpart to the datapath's load shifter/extender. It takes a byte, halfword or word store from the execute stage and writes it into word-only data memory. Sub-word stores use a read-modify-write sequence; misaligned and reserved-size requests are rejected. It sits between the CPU's memory stage and the data RAM port.

---
 rtl/store_pkg.sv | 24 ++
 rtl/store_lane_merge.sv | 39 +++
 rtl/store_merge_unit.sv | 116 +++++++++++
 tb/tb_store_merge_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// Module : store_pkg
// Brief  : Size encodings and FSM state type shared by the store merge unit.
// Rev    : 1.0
// ============================================================================
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_merge.sv
`default_nettype none
// ============================================================================
// Module : store_lane_merge
// Brief  : Replaces the addressed little-endian byte/halfword lanes of a word.
// Rev    : 1.0
// ============================================================================
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old,
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = old;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      // Halfwords are 2-byte aligned, so only lane[1] picks the half.
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = data[15:0];
        else         merged[15:0]  = data[15:0];
      end
      SZ_WORD: merged = data;
      default: merged = old;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module : store_merge_unit
// Brief  : Byte/half/word store into word-only RAM via read-modify-write.
// Rev    : 1.0
// ============================================================================
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_next;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [31:0] r_old;
  logic [31:0] w_merged;

  store_lane_merge u_merge (
    .old    (r_old),
    .data   (r_wdata),
    .lane   (r_lane),
    .size   (r_size),
    .merged (w_merged)
  );

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (size == SZ_RSVD)                        w_state_next = ST_ERR;
          else if (size == SZ_HALF && addr[0])        w_state_next = ST_ERR;
          else if (size == SZ_WORD && addr[1:0] != 0) w_state_next = ST_ERR;
          else if (size == SZ_WORD)                   w_state_next = ST_WRITE;
          else                                        w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_ack)                          w_state_next = ST_MERGE;
        else if (r_wait_cnt == c_timeout_last) w_state_next = ST_ERR;
        else                                  w_wait_cnt_next = r_wait_cnt + 8'd1;
      end
      ST_MERGE: w_state_next = ST_WRITE;
      ST_WRITE: begin
        if (mem_ack)                          w_state_next = ST_DONE;
        else if (r_wait_cnt == c_timeout_last) w_state_next = ST_ERR;
        else                                  w_wait_cnt_next = r_wait_cnt + 8'd1;
      end
      ST_DONE: w_state_next = ST_IDLE;
      ST_ERR:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
      r_lane     <= 2'd0;
      r_size     <= 2'd0;
      r_wdata    <= 32'd0;
      r_old      <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      busy       <= (w_state_next != ST_IDLE);
      done       <= (w_state_next == ST_DONE);
      error      <= (w_state_next == ST_ERR);
      mem_re     <= (w_state_next == ST_READ);
      mem_we     <= (w_state_next == ST_WRITE);
      if (r_state == ST_IDLE && start) begin
        r_lane   <= addr[1:0];
        r_size   <= size;
        r_wdata  <= wdata;
        mem_addr <= {addr[31:2], 2'b00};
        if (w_state_next == ST_WRITE) mem_wdata <= wdata;
      end
      if (r_state == ST_READ && mem_ack) r_old <= mem_rdata;
      if (r_state == ST_MERGE) mem_wdata <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_store_merge_unit
// Brief  : Directed self-checking bench for store_merge_unit (TIMEOUT = 4).
// Rev    : 1.0
// ============================================================================
module tb_store_merge_unit;
  import store_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic [1:0]  size;
  logic        busy, done, error, mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata;

  int checks   = 0;
  int failures = 0;

  // memory model controls
  logic ack_hold_low = 1'b0;
  int   write_delay  = 0;

  // observations of the last run_op
  int          obs_done_cyc, obs_err_cyc, obs_first_re, obs_first_we, obs_re_cnt, obs_we_cnt;
  logic [31:0] obs_wdata, obs_addr;
  logic        obs_overlap, obs_unstable;

  always #5 clk = ~clk;

  store_merge_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one request (start sampled at edge 0) and records what happens in cycles 1..30.
  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic [31:0] rd);
    obs_done_cyc = -1; obs_err_cyc = -1; obs_first_re = -1; obs_first_we = -1;
    obs_re_cnt = 0; obs_we_cnt = 0; obs_wdata = 32'd0; obs_addr = 32'd0;
    obs_overlap = 1'b0; obs_unstable = 1'b0;
    addr = a; wdata = d; size = s; mem_rdata = rd;
    mem_ack = !ack_hold_low;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
      if (mem_re && mem_we) obs_overlap = 1'b1;
      if ((mem_re || mem_we) && obs_first_re < 0 && obs_first_we < 0) obs_addr = mem_addr;
      if (mem_re) begin
        obs_re_cnt++;
        if (obs_first_re < 0) obs_first_re = c;
      end
      if (mem_we) begin
        obs_we_cnt++;
        obs_wdata = mem_wdata;
        if (obs_first_we < 0) obs_first_we = c;
      end
      if ((obs_first_re > 0 || obs_first_we > 0) && mem_addr !== obs_addr) obs_unstable = 1'b1;
      if (done) begin obs_done_cyc = c; break; end
      if (error) begin obs_err_cyc = c; break; end
      mem_ack = mem_we ? (obs_we_cnt > write_delay) : !ack_hold_low;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
    size = 2'd2; mem_rdata = 32'd0; mem_ack = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, error, mem_re, mem_we} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", {busy, done, error, mem_re, mem_we}, 5'b0);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=%h", {mem_addr, mem_wdata}, 64'd0);
    end
    reset = 1'b0; mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_byte;
    run_op(32'h103, 32'hAB, SZ_BYTE, 32'h1122_3344);
    checks++;
    if (obs_done_cyc !== 4) begin failures++; $display("FAIL byte_done_cycle got=%0d exp=4", obs_done_cyc); end
    checks++;
    if (obs_first_re !== 1 || obs_first_we !== 3) begin
      failures++; $display("FAIL byte_req_cycles got=re%0d/we%0d exp=re1/we3", obs_first_re, obs_first_we);
    end
    checks++;
    if (obs_wdata !== 32'hAB22_3344) begin failures++; $display("FAIL byte_wdata got=%h exp=%h", obs_wdata, 32'hAB22_3344); end
    checks++;
    if (obs_addr !== 32'h100 || obs_unstable) begin
      failures++; $display("FAIL byte_addr got=%h unstable=%b exp=%h", obs_addr, obs_unstable, 32'h100);
    end
    checks++;
    if (obs_overlap) begin failures++; $display("FAIL byte_re_we_overlap got=1 exp=0"); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL byte_done_pulse got=done%b/busy%b exp=0/0", done, busy);
    end
  endtask

  task automatic test_half;
    run_op(32'h202, 32'hBEEF, SZ_HALF, 32'hCAFE_1234);
    checks++;
    if (obs_wdata !== 32'hBEEF_1234 || obs_done_cyc !== 4) begin
      failures++; $display("FAIL half_upper got=%h@%0d exp=%h@4", obs_wdata, obs_done_cyc, 32'hBEEF_1234);
    end
    checks++;
    if (obs_addr !== 32'h200) begin failures++; $display("FAIL half_upper_addr got=%h exp=%h", obs_addr, 32'h200); end
    tick();
    run_op(32'h200, 32'hBEEF, SZ_HALF, 32'hCAFE_1234);
    checks++;
    if (obs_wdata !== 32'hCAFE_BEEF || obs_done_cyc !== 4) begin
      failures++; $display("FAIL half_lower got=%h@%0d exp=%h@4", obs_wdata, obs_done_cyc, 32'hCAFE_BEEF);
    end
    tick();
    run_op(32'h301, 32'h5A, SZ_BYTE, 32'h0000_0000);
    checks++;
    if (obs_wdata !== 32'h0000_5A00) begin failures++; $display("FAIL byte_lane1 got=%h exp=%h", obs_wdata, 32'h0000_5A00); end
    tick();
  endtask

  task automatic test_word;
    run_op(32'h40, 32'hDEAD_BEEF, SZ_WORD, 32'h1111_1111);
    checks++;
    if (obs_re_cnt !== 0) begin failures++; $display("FAIL word_no_read got=%0d exp=0", obs_re_cnt); end
    checks++;
    if (obs_first_we !== 1 || obs_done_cyc !== 2) begin
      failures++; $display("FAIL word_timing got=we%0d/done%0d exp=we1/done2", obs_first_we, obs_done_cyc);
    end
    checks++;
    if (obs_wdata !== 32'hDEAD_BEEF || obs_addr !== 32'h40) begin
      failures++; $display("FAIL word_data got=%h@%h exp=%h@%h", obs_wdata, obs_addr, 32'hDEAD_BEEF, 32'h40);
    end
    tick();
  endtask

  task automatic test_reject;
    logic [31:0] ra [3];
    logic [1:0]  rs [3];
    ra[0] = 32'h201; rs[0] = SZ_HALF;
    ra[1] = 32'h42;  rs[1] = SZ_WORD;
    ra[2] = 32'h40;  rs[2] = SZ_RSVD;
    for (int i = 0; i < 3; i++) begin
      run_op(ra[i], 32'h1234_5678, rs[i], 32'h0);
      checks++;
      if (obs_err_cyc !== 1 || obs_re_cnt !== 0 || obs_we_cnt !== 0) begin
        failures++;
        $display("FAIL reject_%0d got=err%0d/re%0d/we%0d exp=err1/re0/we0", i, obs_err_cyc, obs_re_cnt, obs_we_cnt);
      end
      tick();
      checks++;
      if (error !== 1'b0 || busy !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
        failures++; $display("FAIL reject_%0d_idle got=err%b/busy%b exp=0/0", i, error, busy);
      end
    end
  endtask

  task automatic test_timeout;
    ack_hold_low = 1'b1;
    run_op(32'h10, 32'h77, SZ_BYTE, 32'h0);
    ack_hold_low = 1'b0;
    checks++;
    if (obs_re_cnt !== 4 || obs_first_re !== 1 || obs_err_cyc !== 5 || obs_we_cnt !== 0) begin
      failures++;
      $display("FAIL read_timeout got=re%0d/first%0d/err%0d/we%0d exp=re4/first1/err5/we0",
               obs_re_cnt, obs_first_re, obs_err_cyc, obs_we_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0) begin
      failures++; $display("FAIL timeout_idle got=busy%b/re%b exp=0/0", busy, mem_re);
    end
    write_delay = 3;
    run_op(32'h44, 32'hCAFE_F00D, SZ_WORD, 32'h0);
    write_delay = 0;
    checks++;
    if (obs_done_cyc !== 5 || obs_we_cnt !== 4 || obs_err_cyc !== -1) begin
      failures++;
      $display("FAIL write_delay got=done%0d/we%0d/err%0d exp=done5/we4/err-1", obs_done_cyc, obs_we_cnt, obs_err_cyc);
    end
    tick();
  endtask

  task automatic test_reset_mid_write;
    addr = 32'h80; wdata = 32'h1357_9BDF; size = SZ_WORD; mem_ack = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", mem_we); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, error, mem_re, mem_we} !== 5'b0 || mem_addr !== 32'd0) begin
      failures++; $display("FAIL rst_mid_post got=%b/%h exp=%b/%h", {busy, done, error, mem_re, mem_we}, mem_addr, 5'b0, 32'd0);
    end
    addr = 32'h84; wdata = 32'h2468_ACE0; mem_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h84) begin
      failures++; $display("FAIL rst_restart got=we%b/busy%b/%h exp=1/1/%h", mem_we, busy, mem_addr, 32'h84);
    end
    tick();
    checks++;
    if (done !== 1'b1 || mem_wdata !== 32'h2468_ACE0) begin
      failures++; $display("FAIL rst_restart_done got=%b/%h exp=1/%h", done, mem_wdata, 32'h2468_ACE0);
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    // start held high while busy and through DONE; address changes must not leak in
    addr = 32'h103; wdata = 32'hAB; size = SZ_BYTE; mem_rdata = 32'h1122_3344;
    mem_ack = 1'b1; start = 1'b1;
    tick();
    addr = 32'h3FF; wdata = 32'h99;
    tick(); tick();
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hAB22_3344 || mem_addr !== 32'h100) begin
      failures++; $display("FAIL busy_start_ignored got=%b/%h/%h exp=1/%h/%h", mem_we, mem_wdata, mem_addr, 32'hAB22_3344, 32'h100);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_in_done_ignored got=%b exp=0", busy); end
    addr = 32'h48; wdata = 32'h0BAD_CAFE; size = SZ_WORD;
    tick();
    start = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h48 || mem_wdata !== 32'h0BAD_CAFE) begin
      failures++; $display("FAIL b2b_accept got=%b/%h/%h exp=1/%h/%h", mem_we, mem_addr, mem_wdata, 32'h48, 32'h0BAD_CAFE);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    addr = 32'd0; wdata = 32'd0; size = 2'd0; mem_rdata = 32'd0;
    test_reset();
    test_byte();
    test_half();
    test_word();
    test_reject();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
